// File: rtl/seq_alu_unit_if.sv
// Operand/result bundle between the control path and the multi-cycle ALU.
// The master drives the launch request and operands; the slave returns the result, flags and status.
interface seq_alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [3:0]       i_fun_sel;
    logic [WIDTH-1:0] o_alu_out;
    logic [3:0]       o_flags_out;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_a, i_b, i_fun_sel,
        input  o_alu_out, o_flags_out, o_busy, o_done
    );

    modport slave (
        input  i_start, i_a, i_b, i_fun_sel,
        output o_alu_out, o_flags_out, o_busy, o_done
    );
endinterface

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned MUL and DIVU.
// Flags are {Z,C,N,O}; a one-cycle Done marks a fresh result.
module seq_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    seq_alu_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [3:0] OP_ADDC = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_DIV  = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_alu_out, r_hi, r_lo, r_opb;
    logic [3:0]       r_flags, r_fun_sel;
    logic [CNT_W-1:0] r_count;
    logic             r_busy, r_done;

    logic             w_launch_sc, w_launch_it, w_is_iter_in, w_last, w_is_mul;
    logic [WIDTH-1:0] w_add_b, w_sc_res, w_step_hi, w_step_lo, w_div_hi, w_div_lo, w_mul_lo;
    logic             w_add_cin, w_sc_c, w_sc_o, w_add_ovf, w_div_q;
    logic [WIDTH:0]   w_sum, w_mul_sum, w_div_rem, w_div_dif;

    assign w_is_iter_in = (bus.i_fun_sel == OP_MUL) || (bus.i_fun_sel == OP_DIV);
    assign w_is_mul     = (r_fun_sel == OP_MUL);
    assign w_last       = (r_count == CNT_W'(WIDTH - 1));

    // Shared adder: subtraction is A + ~B + 1, add-with-carry feeds the held C flag
    assign w_add_b   = (bus.i_fun_sel == OP_SUB) ? ~bus.i_b : bus.i_b;
    assign w_add_cin = (bus.i_fun_sel == OP_SUB) ? 1'b1 :
                       (bus.i_fun_sel == OP_ADDC) ? r_flags[2] : 1'b0;
    assign w_sum     = {1'b0, bus.i_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_ovf = (bus.i_a[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.i_a[WIDTH-1]);

    // Shift-add multiply step: product accumulates in {hi, lo}, multiplier drains out of lo
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH + 1){1'b0}});
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Restoring divide step: remainder in hi, dividend shifts out of lo as quotient shifts in
    assign w_div_rem = {r_hi, r_lo[WIDTH-1]};
    assign w_div_dif = w_div_rem - {1'b0, r_opb};
    assign w_div_q   = ~w_div_dif[WIDTH];
    assign w_div_hi  = w_div_q ? w_div_dif[WIDTH-1:0] : w_div_rem[WIDTH-1:0];
    assign w_div_lo  = {r_lo[WIDTH-2:0], w_div_q};

    assign w_step_hi = w_is_mul ? w_mul_sum[WIDTH:1] : w_div_hi;
    assign w_step_lo = w_is_mul ? w_mul_lo : w_div_lo;

    // Single-cycle result and the C/O flags it produces
    always_comb begin
        w_sc_res = {WIDTH{1'b0}};
        w_sc_c   = r_flags[2];
        w_sc_o   = r_flags[0];
        case (bus.i_fun_sel)
            4'b0000: w_sc_res = bus.i_a;
            4'b0001: w_sc_res = bus.i_b;
            4'b0010: w_sc_res = ~bus.i_a;
            4'b0011, 4'b0100, 4'b0101: begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
                w_sc_o   = w_add_ovf;
            end
            4'b0110: w_sc_res = bus.i_a & bus.i_b;
            4'b0111: w_sc_res = bus.i_a | bus.i_b;
            4'b1000: w_sc_res = bus.i_a ^ bus.i_b;
            4'b1001: w_sc_res = ~(bus.i_a & bus.i_b);
            4'b1010: begin w_sc_res = {bus.i_a[WIDTH-2:0], 1'b0};         w_sc_c = bus.i_a[WIDTH-1]; end
            4'b1011: begin w_sc_res = {1'b0, bus.i_a[WIDTH-1:1]};         w_sc_c = bus.i_a[0];       end
            4'b1100: begin w_sc_res = {bus.i_a[WIDTH-1], bus.i_a[WIDTH-1:1]}; w_sc_c = bus.i_a[0];   end
            4'b1101: begin w_sc_res = {bus.i_a[WIDTH-2:0], r_flags[2]};  w_sc_c = bus.i_a[WIDTH-1]; end
            default: w_sc_res = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic; Start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_launch_sc = 1'b0;
        w_launch_it = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start && w_is_iter_in) begin
                    w_state_nxt = ST_EXEC;
                    w_launch_it = 1'b1;
                end else if (bus.i_start) begin
                    w_state_nxt = ST_DONE;
                    w_launch_sc = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, operand latches, iteration registers and registered outputs
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_alu_out <= {WIDTH{1'b0}};
            r_flags   <= 4'b0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= {CNT_W{1'b0}};
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
            r_opb     <= {WIDTH{1'b0}};
            r_fun_sel <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_launch_sc) begin
                r_alu_out <= w_sc_res;
                r_flags   <= {(w_sc_res == {WIDTH{1'b0}}), w_sc_c, w_sc_res[WIDTH-1], w_sc_o};
            end else if ((r_state == ST_EXEC) && w_last) begin
                r_alu_out <= w_step_lo;
                r_flags   <= {(w_step_lo == {WIDTH{1'b0}}),
                              (w_is_mul ? (|w_step_hi) : r_flags[2]),
                              w_step_lo[WIDTH-1],
                              (w_is_mul ? r_flags[0] : (r_opb == {WIDTH{1'b0}}))};
            end
            if (w_launch_it) begin
                r_fun_sel <= bus.i_fun_sel;
                r_count   <= {CNT_W{1'b0}};
                r_hi      <= {WIDTH{1'b0}};
                r_lo      <= (bus.i_fun_sel == OP_MUL) ? bus.i_b : bus.i_a;
                r_opb     <= (bus.i_fun_sel == OP_MUL) ? bus.i_a : bus.i_b;
            end else if (r_state == ST_EXEC) begin
                r_hi    <= w_step_hi;
                r_lo    <= w_step_lo;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.o_alu_out   = r_alu_out;
    assign bus.o_flags_out = r_flags;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed plus randomized-operand checks of seq_alu_unit against a scoreboard of expected results.
module tb_seq_alu_unit;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [35:0] sb_q[$];
    logic [3:0]  exp_flags;

    seq_alu_unit_if #(.WIDTH(32)) bus ();

    seq_alu_unit #(.WIDTH(32)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Independent reference: wide arithmetic and native operators
    function automatic logic [35:0] model(input logic [3:0] fs, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] f);
        logic [31:0] r;
        logic [63:0] w;
        logic [33:0] s;
        logic        c, o;
        c = f[2]; o = f[0]; r = 32'd0; w = 64'd0; s = 34'd0;
        case (fs)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3, 4'h4: begin
                w = {32'd0, a} + {32'd0, b} + ((fs == 4'h4 && f[2]) ? 64'd1 : 64'd0);
                s = {{2{a[31]}}, a} + {{2{b[31]}}, b} + ((fs == 4'h4 && f[2]) ? 34'd1 : 34'd0);
                r = w[31:0]; c = w[32]; o = (s[32] != s[31]);
            end
            4'h5: begin
                s = {{2{a[31]}}, a} - {{2{b[31]}}, b};
                r = a - b; c = (a >= b); o = (s[32] != s[31]);
            end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = a ^ b;
            4'h9: r = ~(a & b);
            4'hA: begin r = a << 1; c = a[31]; end
            4'hB: begin r = a >> 1; c = a[0]; end
            4'hC: begin r = $unsigned($signed(a) >>> 1); c = a[0]; end
            4'hD: begin r = {a[30:0], f[2]}; c = a[31]; end
            4'hE: begin w = {32'd0, a} * {32'd0, b}; r = w[31:0]; c = |w[63:32]; end
            default: begin r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b; o = (b == 32'd0); end
        endcase
        return {r, (r == 32'd0), c, r[31], o};
    endfunction

    // Launch one op, then wait (bounded) for Done and compare against the scoreboard
    task automatic run_op(input string tag, input logic [3:0] fs, input logic [31:0] a,
                          input logic [31:0] b, input logic [35:0] exp, input int elat, input bit hold);
        int cycles;
        logic [35:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_fun_sel = fs; bus.i_a = a; bus.i_b = b;
        @(posedge clk);
        #1;
        bus.i_start = hold; bus.i_a = $urandom(); bus.i_b = $urandom(); bus.i_fun_sel = 4'($urandom());
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (elat > 1 && cycles == 16) chk({tag, "_busy_mid"}, {62'd0, bus.o_busy, bus.o_done}, 64'd2);
            if (bus.o_done) break;
        end
        chk({tag, "_latency"}, 64'(cycles), 64'(elat));
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 36'hF_FFFF_FFFF;
        chk({tag, "_result"}, 64'(bus.o_alu_out), 64'(e[35:4]));
        chk({tag, "_flags"}, 64'(bus.o_flags_out), 64'(e[3:0]));
        exp_flags = e[3:0];
        if (hold) begin
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_idle_after"}, {62'd0, bus.o_busy, bus.o_done}, 64'd0);
    endtask

    initial begin
        int dn;
        logic [31:0] ra, rb;
        rst = 1'b0;
        bus.i_start = 1'b0; bus.i_a = 32'd0; bus.i_b = 32'd0; bus.i_fun_sel = 4'd0;
        exp_flags = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 64'(bus.o_alu_out), 64'd0);
        chk("rst_flags", 64'(bus.o_flags_out), 64'd0);
        chk("rst_busy_done", {62'd0, bus.o_busy, bus.o_done}, 64'd0);
        rst = 1'b1;

        run_op("add_5_7",   4'b0011, 32'd5,          32'd7, {32'd12, 4'b0000},          1, 1'b0);
        run_op("add_ovf",   4'b0011, 32'h7FFF_FFFF,  32'd1, {32'h8000_0000, 4'b0011},   1, 1'b0);
        run_op("add_wrap",  4'b0011, 32'hFFFF_FFFF,  32'd1, {32'd0, 4'b1100},           1, 1'b0);
        run_op("mul_hold",  4'b1110, 32'h0001_0000, 32'h0001_0003, {32'h0003_0000, 4'b0100}, 33, 1'b1);
        run_op("div_100_7", 4'b1111, 32'd100,        32'd7, {32'd14, 4'b0100},          33, 1'b0);
        run_op("div_by0",   4'b1111, 32'd9,          32'd0, {32'hFFFF_FFFF, 4'b0111},   33, 1'b0);
        run_op("set_c",     4'b0011, 32'hFFFF_FFFF,  32'd1, {32'd0, 4'b1100},           1, 1'b0);
        run_op("addc",      4'b0100, 32'd1,          32'd1, {32'd3, 4'b0000},           1, 1'b0);
        run_op("lsr_1",     4'b1011, 32'd1,          32'd0, {32'd0, 4'b1100},           1, 1'b0);
        run_op("sub_neg",   4'b0101, 32'd5,          32'd7, {32'hFFFF_FFFE, 4'b0010},   1, 1'b0);
        run_op("sub_ovf",   4'b0101, 32'h8000_0000,  32'd1, {32'h7FFF_FFFF, 4'b0101},   1, 1'b0);
        run_op("csl",       4'b1101, 32'h8000_0001,  32'd0, {32'd3, 4'b0101},           1, 1'b0);

        // Reset in the middle of a multiply: everything clears and no Done follows
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_fun_sel = 4'b1110; bus.i_a = 32'd3; bus.i_b = 32'd5;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_out", 64'(bus.o_alu_out), 64'd0);
        chk("abort_flags", 64'(bus.o_flags_out), 64'd0);
        chk("abort_busy_done", {62'd0, bus.o_busy, bus.o_done}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        exp_flags = 4'b0000;

        for (int i = 0; i < 16; i++) begin
            ra = $urandom();
            rb = (i == 15) ? 32'($urandom_range(1, 70000)) : $urandom();
            run_op($sformatf("rand_op%0d", i), 4'(i), ra, rb, model(4'(i), ra, rb, exp_flags),
                   (i >= 14) ? 33 : 1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
